// File: rtl/pag_cache_pkg.sv
// pag_cache_pkg: shared definitions for the PAG-to-MEM word cache.
//   PAG_PADDR_W / PAG_WORD_W track the machine-wide `PADDR (22) and `WORD (36)
//   widths; PAG_IDX_W is the default index width (64 one-word lines).
//   state_t is the controller FSM encoding used by pag_cache.
package pag_cache_pkg;

    localparam int PAG_PADDR_W = 22;
    localparam int PAG_WORD_W  = 36;
    localparam int PAG_IDX_W   = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACK   = 2'd1,
        MISS  = 2'd2,
        WRITE = 2'd3
    } state_t;

endpackage

// File: rtl/pag_cache_store.sv
// pag_cache_store: tag + data arrays and per-line valid bits.
//   Ports:
//     clk, reset        clock, async active-low reset (clears valid bits)
//     lookup_idx/tag    combinational lookup address
//     lookup_hit/data   hit flag and stored word for lookup_idx
//     wr_en/idx/tag/data  write port; also marks the line valid
//     clear             invalidate every line in one cycle (wins over wr_en)
module pag_cache_store
    import pag_cache_pkg::*;
#(
    parameter int IDX_W   = PAG_IDX_W,
    parameter int PADDR_W = PAG_PADDR_W,
    parameter int WORD_W  = PAG_WORD_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [IDX_W-1:0]         lookup_idx,
    input  logic [PADDR_W-IDX_W-1:0] lookup_tag,
    output logic                     lookup_hit,
    output logic [WORD_W-1:0]        lookup_data,
    input  logic                     wr_en,
    input  logic [IDX_W-1:0]         wr_idx,
    input  logic [PADDR_W-IDX_W-1:0] wr_tag,
    input  logic [WORD_W-1:0]        wr_data,
    input  logic                     clear
);

    localparam int LINES = 2 ** IDX_W;
    localparam int TAG_W = PADDR_W - IDX_W;

    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [WORD_W-1:0] data_mem [LINES];
    logic [LINES-1:0]  valid;

    assign lookup_hit  = valid[lookup_idx] && (tag_mem[lookup_idx] == lookup_tag);
    assign lookup_data = data_mem[lookup_idx];

    // Arrays carry no reset; a line is only trusted once its valid bit is set.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= '0;
        end else if (clear) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

endmodule

// File: rtl/pag_cache.sv
// pag_cache: direct-mapped, write-through, no-write-allocate word cache
// between the pager (PAG) and main memory (MEM), memory space only.
//   Ports:
//     clk, reset            clock, async active-low reset
//     flush                 invalidate all lines (deferred to IDLE if busy)
//     pag_addr/read/write/write_data   PAG level requests
//     pag_read_data/read_ack/write_ack PAG one-cycle completions
//     mem_addr/read/write/write_data   MEM level requests (held until ack)
//     mem_read_data/read_ack/write_ack MEM completions
//   Optional: define PAG_CACHE_STATS_EN to add hit_count / miss_count
//   read statistics outputs (cleared by reset only, wrap at 2**WORD_W).
//
//   state | meaning
//   IDLE  | waiting for a PAG request; pending flush applied here
//   ACK   | one-cycle pag_read_ack or pag_write_ack is on the outputs
//   MISS  | mem_read outstanding, waiting for mem_read_ack
//   WRITE | mem_write outstanding, waiting for mem_write_ack
module pag_cache
    import pag_cache_pkg::*;
#(
    parameter int IDX_W   = PAG_IDX_W,
    parameter int PADDR_W = PAG_PADDR_W,
    parameter int WORD_W  = PAG_WORD_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic [PADDR_W-1:0] pag_addr,
    input  logic               pag_read,
    input  logic               pag_write,
    input  logic [WORD_W-1:0]  pag_write_data,
    output logic [WORD_W-1:0]  pag_read_data,
    output logic               pag_read_ack,
    output logic               pag_write_ack,
    output logic [PADDR_W-1:0] mem_addr,
    output logic               mem_read,
    output logic               mem_write,
    output logic [WORD_W-1:0]  mem_write_data,
    input  logic [WORD_W-1:0]  mem_read_data,
    input  logic               mem_read_ack,
    input  logic               mem_write_ack
`ifdef PAG_CACHE_STATS_EN
    ,
    output logic [WORD_W-1:0]  hit_count,
    output logic [WORD_W-1:0]  miss_count
`endif
);

    localparam int TAG_W = PADDR_W - IDX_W;

    state_t state, state_d;

    logic               flush_pend, flush_pend_d;
    logic               flush_now;
    logic               lookup_hit, hit;
    logic [WORD_W-1:0]  lookup_data;
    logic [IDX_W-1:0]   idx;
    logic [TAG_W-1:0]   tag;
    logic               st_wr_en;
    logic [WORD_W-1:0]  st_wr_data;

    logic [WORD_W-1:0]  rdata_d;
    logic               rack_d, wack_d;
    logic [PADDR_W-1:0] maddr_d;
    logic               mread_d, mwrite_d;
    logic [WORD_W-1:0]  mwdata_d;

    assign idx = pag_addr[IDX_W-1:0];
    assign tag = pag_addr[PADDR_W-1:IDX_W];

    // A flush seen in IDLE (fresh or deferred) clears the store this cycle and
    // forces any same-cycle lookup to behave as a miss.
    assign flush_now = (state == IDLE) && (flush || flush_pend);
    assign hit       = lookup_hit && !flush_now;

    pag_cache_store #(
        .IDX_W   (IDX_W),
        .PADDR_W (PADDR_W),
        .WORD_W  (WORD_W)
    ) u_store (
        .clk         (clk),
        .reset       (reset),
        .lookup_idx  (idx),
        .lookup_tag  (tag),
        .lookup_hit  (lookup_hit),
        .lookup_data (lookup_data),
        .wr_en       (st_wr_en),
        .wr_idx      (idx),
        .wr_tag      (tag),
        .wr_data     (st_wr_data),
        .clear       (flush_now)
    );

    always_comb begin
        state_d      = state;
        flush_pend_d = flush_pend;
        rdata_d      = pag_read_data;
        rack_d       = 1'b0;
        wack_d       = 1'b0;
        maddr_d      = mem_addr;
        mread_d      = mem_read;
        mwrite_d     = mem_write;
        mwdata_d     = mem_write_data;
        st_wr_en     = 1'b0;
        st_wr_data   = pag_write_data;

        if (state != IDLE && flush) begin
            flush_pend_d = 1'b1;
        end

        case (state)
            IDLE: begin
                flush_pend_d = 1'b0;
                // Write wins if a requester wrongly raises both.
                if (pag_write) begin
                    mwrite_d = 1'b1;
                    maddr_d  = pag_addr;
                    mwdata_d = pag_write_data;
                    st_wr_en = hit;
                    state_d  = WRITE;
                end else if (pag_read) begin
                    if (hit) begin
                        rdata_d = lookup_data;
                        rack_d  = 1'b1;
                        state_d = ACK;
                    end else begin
                        mread_d = 1'b1;
                        maddr_d = pag_addr;
                        state_d = MISS;
                    end
                end
            end
            MISS: begin
                if (mem_read_ack) begin
                    mread_d    = 1'b0;
                    st_wr_en   = 1'b1;
                    st_wr_data = mem_read_data;
                    rdata_d    = mem_read_data;
                    rack_d     = 1'b1;
                    state_d    = ACK;
                end
            end
            WRITE: begin
                if (mem_write_ack) begin
                    mwrite_d = 1'b0;
                    wack_d   = 1'b1;
                    state_d  = ACK;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            flush_pend     <= 1'b0;
            pag_read_data  <= '0;
            pag_read_ack   <= 1'b0;
            pag_write_ack  <= 1'b0;
            mem_addr       <= '0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_write_data <= '0;
        end else begin
            state          <= state_d;
            flush_pend     <= flush_pend_d;
            pag_read_data  <= rdata_d;
            pag_read_ack   <= rack_d;
            pag_write_ack  <= wack_d;
            mem_addr       <= maddr_d;
            mem_read       <= mread_d;
            mem_write      <= mwrite_d;
            mem_write_data <= mwdata_d;
        end
    end

`ifdef PAG_CACHE_STATS_EN
    logic read_lookup;
    assign read_lookup = (state == IDLE) && pag_read && !pag_write;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (read_lookup) begin
            if (hit) begin
                hit_count <= hit_count + WORD_W'(1);
            end else begin
                miss_count <= miss_count + WORD_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pag_cache.sv
// tb_pag_cache: scoreboard bench for pag_cache. Requests push their expected
// PAG completion into a queue; a monitor pops and compares on every ack.
module tb_pag_cache;
    import pag_cache_pkg::*;

    localparam int AW = PAG_PADDR_W;
    localparam int DW = PAG_WORD_W;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic [AW-1:0] pag_addr;
    logic          pag_read, pag_write;
    logic [DW-1:0] pag_write_data;
    logic [DW-1:0] pag_read_data;
    logic          pag_read_ack, pag_write_ack;
    logic [AW-1:0] mem_addr;
    logic          mem_read, mem_write;
    logic [DW-1:0] mem_write_data;
    logic [DW-1:0] mem_read_data;
    logic          mem_read_ack, mem_write_ack;
`ifdef PAG_CACHE_STATS_EN
    logic [DW-1:0] hit_count, miss_count;
`endif

    pag_cache dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .pag_addr       (pag_addr),
        .pag_read       (pag_read),
        .pag_write      (pag_write),
        .pag_write_data (pag_write_data),
        .pag_read_data  (pag_read_data),
        .pag_read_ack   (pag_read_ack),
        .pag_write_ack  (pag_write_ack),
        .mem_addr       (mem_addr),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .mem_read_ack   (mem_read_ack),
        .mem_write_ack  (mem_write_ack)
`ifdef PAG_CACHE_STATS_EN
        ,
        .hit_count      (hit_count),
        .miss_count     (miss_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          is_wr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    int n_pass = 0;
    int n_total = 0;

    int            rd_cnt = 0, wr_cnt = 0;
    logic [AW-1:0] last_rd_addr, last_wr_addr;
    logic [DW-1:0] last_wr_data;
    logic [DW-1:0] mem_m [logic [AW-1:0]];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic flag(input string name);
        n_total++;
        $display("FAIL %s: event seen, none expected", name);
    endtask

    // MEM model: read latency 3 cycles, write latency 2 cycles.
    initial begin
        mem_read_ack  = 1'b0;
        mem_write_ack = 1'b0;
        mem_read_data = '0;
        forever begin
            @(negedge clk);
            if (reset && mem_read) begin
                rd_cnt++;
                last_rd_addr = mem_addr;
                repeat (3) @(posedge clk);
                #1;
                mem_read_data = mem_m.exists(last_rd_addr) ? mem_m[last_rd_addr] : '0;
                mem_read_ack  = 1'b1;
                @(posedge clk);
                #1;
                mem_read_ack  = 1'b0;
            end else if (reset && mem_write) begin
                wr_cnt++;
                last_wr_addr = mem_addr;
                last_wr_data = mem_write_data;
                repeat (2) @(posedge clk);
                #1;
                mem_m[last_wr_addr] = last_wr_data;
                mem_write_ack = 1'b1;
                @(posedge clk);
                #1;
                mem_write_ack = 1'b0;
            end
        end
    end

    // Monitor: compare every PAG completion against the scoreboard head.
    initial begin
        logic prev_ack;
        exp_t e;
        prev_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (reset && (pag_read_ack || pag_write_ack)) begin
                if (prev_ack) flag("ack_back_to_back");
                if (sb.size() == 0) begin
                    flag("unexpected_ack");
                end else begin
                    e = sb.pop_front();
                    chk("ack_kind", 64'(pag_write_ack), 64'(e.is_wr));
                    chk("ack_single", 64'(pag_read_ack ^ pag_write_ack), 64'd1);
                    if (!e.is_wr) chk("read_data", 64'(pag_read_data), 64'(e.data));
                end
            end
            prev_ack = pag_read_ack || pag_write_ack;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // fmode: 0 none, 1 flush pulse while the miss is outstanding,
    //        2 flush in the same cycle the request is first sampled.
    task automatic do_read(input string name, input logic [AW-1:0] addr,
                           input logic [DW-1:0] exp_data, input bit exp_miss, input int fmode);
        int rd0, lat;
        rd0 = rd_cnt;
        lat = 0;
        sb.push_back({1'b0, exp_data});
        pag_addr = addr;
        pag_read = 1'b1;
        if (fmode == 2) flush = 1'b1;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) begin
                if (fmode == 2) flush = 1'b0;
                if (fmode == 1) flush = 1'b1;
            end else if (lat == 2 && fmode == 1) begin
                flush = 1'b0;
            end
        end while (!pag_read_ack && lat < 40);
        pag_read = 1'b0;
        flush = 1'b0;
        chk({name, "_latency"}, 64'(lat), exp_miss ? 64'd5 : 64'd1);
        chk({name, "_mem_reads"}, 64'(rd_cnt - rd0), exp_miss ? 64'd1 : 64'd0);
        if (exp_miss) chk({name, "_mem_addr"}, 64'(last_rd_addr), 64'(addr));
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input string name, input logic [AW-1:0] addr,
                            input logic [DW-1:0] data, input bit also_read);
        int rd0, wr0, lat;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        lat = 0;
        sb.push_back({1'b1, {DW{1'b0}}});
        pag_addr       = addr;
        pag_write_data = data;
        pag_write      = 1'b1;
        pag_read       = also_read;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!pag_write_ack && lat < 40);
        pag_write = 1'b0;
        pag_read  = 1'b0;
        chk({name, "_latency"}, 64'(lat), 64'd4);
        chk({name, "_mem_writes"}, 64'(wr_cnt - wr0), 64'd1);
        chk({name, "_mem_reads"}, 64'(rd_cnt - rd0), 64'd0);
        chk({name, "_mem_addr"}, 64'(last_wr_addr), 64'(addr));
        chk({name, "_mem_data"}, 64'(last_wr_data), 64'(data));
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset          = 1'b0;
        flush          = 1'b0;
        pag_addr       = '0;
        pag_read       = 1'b0;
        pag_write      = 1'b0;
        pag_write_data = '0;

        mem_m[22'o0001000]  = 36'o123456701234;
        mem_m[22'o0002000]  = 36'o000011112222;
        mem_m[22'o0003077]  = 36'o765432107654;
        mem_m[22'o0004000]  = 36'o444455556666;
        mem_m[22'o0005000]  = 36'o101010101010;
        mem_m[22'o17001000] = 36'o222233334444;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctrl", 64'({pag_read_ack, pag_write_ack, mem_read, mem_write, mem_addr}), 64'd0);
        chk("reset_data", 64'(pag_read_data | mem_write_data), 64'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        do_read("cold_read", 22'o0001000, 36'o123456701234, 1'b1, 0);
        do_read("hit_read", 22'o0001000, 36'o123456701234, 1'b0, 0);
        do_write("write_hit", 22'o0001000, 36'o777777777777, 1'b0);
        do_read("read_after_write", 22'o0001000, 36'o777777777777, 1'b0, 0);
        do_read("tag_msb_miss", 22'o17001000, 36'o222233334444, 1'b1, 0);
        do_read("reread_1000", 22'o0001000, 36'o777777777777, 1'b1, 0);
        do_read("conflict_2000", 22'o0002000, 36'o000011112222, 1'b1, 0);
        do_read("conflict_back", 22'o0001000, 36'o777777777777, 1'b1, 0);
        do_write("write_nalloc", 22'o0003077, 36'o135713571357, 1'b0);
        do_read("read_nalloc", 22'o0003077, 36'o135713571357, 1'b1, 0);
        do_read("hit_top_index", 22'o0003077, 36'o135713571357, 1'b0, 0);
        do_read("flush_mid_miss", 22'o0004000, 36'o444455556666, 1'b1, 1);
        do_read("after_flush", 22'o0004000, 36'o444455556666, 1'b1, 0);
        do_read("hit_4000", 22'o0004000, 36'o444455556666, 1'b0, 0);
        do_read("flush_same_cycle", 22'o0004000, 36'o444455556666, 1'b1, 2);

        // Reset in the middle of a miss on 0o005000.
        pag_addr = 22'o0005000;
        pag_read = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("miss_outstanding", 64'(mem_read), 64'd1);
        reset = 1'b0;
        #1;
        chk("midreset_ctrl", 64'({pag_read_ack, pag_write_ack, mem_read, mem_write, mem_addr}), 64'd0);
        chk("midreset_wdata", 64'(mem_write_data), 64'd0);
        chk("midreset_rdata", 64'(pag_read_data), 64'd0);
        pag_read = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (8) @(posedge clk);
        #1;

        do_read("post_reset_miss", 22'o0003077, 36'o135713571357, 1'b1, 0);
        do_write("rd_wr_collide", 22'o0003077, 36'o000000000077, 1'b1);
        do_read("collide_hit", 22'o0003077, 36'o000000000077, 1'b0, 0);

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pag_cache.md
Name: pag_cache

Overview:
- Direct-mapped, write-through, no-write-allocate word cache between the pager (PAG) and main memory (MEM).
- Occupies the slot where PAG memory traffic currently passes straight to MEM.
- Memory space only; I/O traffic is handled elsewhere.
- Same level-request / one-cycle-ack handshake on both sides.

Parameters:
- IDX_W, 6, index bits; LINES = 2**IDX_W one-word lines.
- PADDR_W, 22, physical address width.
- WORD_W, 36, data word width.

Ports:
- clk  in  1  system clock (APR clock domain)
- reset  in  1  asynchronous, active-low reset
- flush  in  1  invalidate all lines
- pag_addr  in  PADDR_W  physical address from PAG
- pag_read  in  1  read request (level)
- pag_write  in  1  write request (level)
- pag_write_data  in  WORD_W  write data
- pag_read_data  out  WORD_W  read data, valid with pag_read_ack
- pag_read_ack  out  1  one-cycle read completion pulse
- pag_write_ack  out  1  one-cycle write completion pulse
- mem_addr  out  PADDR_W  address to MEM
- mem_read  out  1  memory read request (level)
- mem_write  out  1  memory write request (level)
- mem_write_data  out  WORD_W  data to MEM
- mem_read_data  in  WORD_W  data from MEM, valid with mem_read_ack
- mem_read_ack  in  1  MEM read completion pulse
- mem_write_ack  in  1  MEM write completion pulse

Behaviour:
- Address split:
  - index = pag_addr[IDX_W-1:0]
  - tag = pag_addr[PADDR_W-1:IDX_W]
- Storage:
  - tag and data arrays, LINES entries, combinational read.
  - valid bit vector held in flops.
- Reset (reset low, async):
  - state=IDLE; all valid bits 0.
  - All outputs 0 (acks, mem_read, mem_write, data/addr buses).
- Handshake:
  - Requester holds the request and its address/data until it sees the ack.
  - Requester drops the request on the edge that samples the ack.
  - Acks are registered, one cycle wide, never asserted back-to-back.
- FSM states: IDLE, ACK, MISS, WRITE.
- IDLE, pag_write high:
  - Drive mem_write=1, mem_addr, mem_write_data from the request.
  - On a hit, update the data array word now.
  - Go to WRITE.
- IDLE, pag_read high, hit (valid & tag match):
  - Register the data word and pulse pag_read_ack next cycle (state ACK).
  - Hit latency is 1 cycle: request sampled at edge N, ack high in cycle N+1.
- IDLE, pag_read high, miss:
  - Drive mem_read=1 with mem_addr=pag_addr; go to MISS.
- MISS, on mem_read_ack:
  - Drop mem_read; write tag/data; set valid.
  - Register mem_read_data to pag_read_data; go to ACK.
- WRITE, on mem_write_ack:
  - Drop mem_write; go to ACK.
  - Writes never allocate on a miss.
- ACK:
  - Assert the matching pag ack for exactly one cycle, then IDLE.
- Simultaneous pag_read and pag_write in IDLE: protocol violation; write has priority, read ignored.
- mem_* requests stay asserted and stable until the corresponding mem ack; no timeout.
- Stray mem acks in IDLE/ACK are ignored.
- Flush:
  - Clears all valid bits in one cycle when state is IDLE.
  - If asserted while busy, it is latched and applied on the first IDLE cycle.
  - Flush takes precedence over a same-cycle lookup: that request is treated as a miss.
- Reset mid-transaction: immediate return to IDLE; outstanding mem ack is discarded.
- Index 0 and index LINES-1 follow the same rules; tags compare all PADDR_W-IDX_W bits.

Optional Feature:
- Macro: PAG_CACHE_STATS_EN.
- When defined, two extra outputs are added:
  - hit_count[WORD_W-1:0], incremented on each read hit.
  - miss_count[WORD_W-1:0], incremented on each read miss.
- Both are cleared by reset, not by flush, and wrap modulo 2**WORD_W.
- Without the macro: no counters and no extra ports; behaviour otherwise identical.

Decomposition:
- Shared package:
  - FSM state enum (IDLE, ACK, MISS, WRITE).
  - PADDR_W/WORD_W constants, consistent with `PADDR and `WORD.
- One natural sub-module, pag_cache_store: tag+data arrays plus valid vector, with combinational lookup, write port and one-cycle clear.

Test Plan:
- Cold read 0o001000; MEM acks after 3 cycles with 0o123456701234 -> one mem_read; pag_read_ack 1 cycle after mem_read_ack with same data.
- Repeat read 0o001000 -> no mem_read; pag_read_ack 1 cycle after request, data 0o123456701234.
- Write 0o777777777777 to 0o001000 (hit) -> mem_write with that data; pag_write_ack after mem_write_ack; following read hits, returns 0o777777777777.
- Conflict: read 0o001000 then read 0o002000 (same index 0o00, different tag) -> second misses and replaces; re-read of 0o001000 misses again.
- Write to uncached 0o003077 then read 0o003077 -> write does not allocate; the read issues mem_read.
- Flush pulsed during an outstanding miss on 0o004000 -> miss completes with correct data; subsequent read of 0o004000 misses. Reset low mid-miss -> all outputs 0, valid cleared.
